// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO with registered read data,
// threshold flags, fill level and sticky overflow/underflow error flags.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   wr_en_i, data_in_i  write request and write data
//   rd_en_i             read request; data_out_o/rd_valid_o follow one cycle later
//   clr_err_i           synchronous clear of overflow_o/underflow_o
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o  occupancy status
//   overflow_o, underflow_o  sticky rejected-access flags
module sync_fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc, wr_acc;
    assign full_o         = count_q == CW'(DEPTH);
    assign empty_o        = count_q == '0;
    assign almost_full_o  = count_q >= CW'(AF_THRESH);
    assign almost_empty_o = count_q <= CW'(AE_THRESH);
    assign count_o        = count_q;
    assign data_out_o     = data_q;
    assign rd_valid_o     = valid_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign rd_acc = rd_en_i & ~empty_o;
    // a full FIFO still takes a write when the same cycle frees a slot
    assign wr_acc = wr_en_i & (~full_o | rd_acc);
    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        data_d   = rd_acc ? mem_q[rd_ptr_q] : data_q;
        count_d  = (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                   (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
        // a new error event outranks a coincident clear
        ovf_d    = (wr_en_i & ~wr_acc) | (ovf_q & ~clr_err_i);
        unf_d    = (rd_en_i & ~rd_acc) | (unf_q & ~clr_err_i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= rd_acc;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in_i;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param at default parameters.
module tb_sync_fifo_param;
    localparam int W = 32;
    localparam int D = 16;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    count;
    logic [W-1:0]  sb [$];
    int            m_count = 0;
    logic          m_ovf = 1'b0, m_unf = 1'b0;
    int            total = 0, bad = 0;
    sync_fifo_param dut (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .data_in_i(data_in), .clr_err_i(clr_err), .data_out_o(data_out),
        .rd_valid_o(rd_valid), .full_o(full), .empty_o(empty),
        .almost_full_o(almost_full), .almost_empty_o(almost_empty),
        .count_o(count), .overflow_o(overflow), .underflow_o(underflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_status(input string tag);
        chk({tag, ".count"}, W'(count), W'(m_count));
        chk({tag, ".empty"}, W'(empty), W'(m_count == 0));
        chk({tag, ".full"}, W'(full), W'(m_count == D));
        chk({tag, ".afull"}, W'(almost_full), W'(m_count >= D - 2));
        chk({tag, ".aempty"}, W'(almost_empty), W'(m_count <= 2));
        chk({tag, ".ovf"}, W'(overflow), W'(m_ovf));
        chk({tag, ".unf"}, W'(underflow), W'(m_unf));
    endtask
    // one clock of stimulus; the model predicts acceptance from its own count
    task automatic step(input logic wr, input logic rd, input logic [W-1:0] d, input string tag);
        logic ra, wa;
        logic [W-1:0] exp;
        exp = '0;
        wr_en = wr;
        rd_en = rd;
        data_in = d;
        ra = rd && m_count != 0;
        wa = wr && (m_count != D || ra);
        if (ra) exp = sb.pop_front();
        if (wa) sb.push_back(d);
        m_count += (wa ? 1 : 0) - (ra ? 1 : 0);
        m_ovf = (wr && !wa) || (m_ovf && !clr_err);
        m_unf = (rd && !ra) || (m_unf && !clr_err);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk({tag, ".rd_valid"}, W'(rd_valid), W'(ra));
        if (ra) chk({tag, ".data"}, data_out, exp);
        chk_status(tag);
    endtask
    initial begin
        #12;
        chk("reset.data_out", data_out, '0);
        chk("reset.rd_valid", W'(rd_valid), '0);
        chk_status("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, '0, "idle");
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, W'(i), "fill");
            if (i == 13) chk("af_13", W'(almost_full), '0);
            if (i == 14) chk("af_14", W'(almost_full), 1);
        end
        chk("full16", W'(full), 1);
        for (int i = 0; i < 16; i++) step(0, 1, '0, "drain");
        chk("empty_end", W'(empty), 1);
        for (int i = 0; i < 16; i++) step(1, 0, W'(32'h100 + i), "refill");
        step(1, 0, W'(32'hDEAD), "ovf_wr");
        chk("ovf_set", W'(overflow), 1);
        step(1, 1, W'(32'hBEEF), "full_rw");
        for (int i = 0; i < 16; i++) step(0, 1, '0, "drain2");
        clr_err = 1'b1;
        step(0, 0, '0, "clr1");
        clr_err = 1'b0;
        chk("ovf_clr", W'(overflow), '0);
        step(1, 1, W'(32'hA5), "empty_rw");
        chk("unf_set", W'(underflow), 1);
        step(0, 1, '0, "read_a5");
        clr_err = 1'b1;
        step(0, 1, '0, "clr_vs_unf");
        clr_err = 1'b0;
        chk("set_wins", W'(underflow), 1);
        step(1, 0, W'(32'h200), "wrap_pre");
        step(1, 0, W'(32'h201), "wrap_pre");
        for (int i = 2; i < 24; i++) begin
            if (i % 3 == 0) step(1, 0, W'(32'h200 + i), "wrap_w");
            else step(1, 1, W'(32'h200 + i), "wrap_rw");
            if (m_count > 3) step(0, 1, '0, "wrap_r");
        end
        while (m_count > 0) step(0, 1, '0, "wrap_drain");
        clr_err = 1'b1;
        step(0, 0, '0, "clr2");
        clr_err = 1'b0;
        chk("unf_clr", W'(underflow), '0);
        for (int i = 0; i < 8; i++) step(1, 0, W'(32'h300 + i), "burst");
        step(0, 1, '0, "burst_rd");
        chk("burst_cnt7", W'(count), 7);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        m_count = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("arst.count", W'(count), '0);
        chk("arst.empty", W'(empty), 1);
        chk("arst.rd_valid", W'(rd_valid), '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.rd_valid", W'(rd_valid), '0);
        step(0, 0, '0, "post_rst");
        step(0, 0, '0, "post_rst");
        step(1, 0, W'(32'h77), "post_w");
        step(0, 1, '0, "post_r");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 16x32 FIFO.
- Configurable data width and depth.
- Adds registered read data with a valid strobe, almost-full/almost-empty thresholds, and a fill-level output.
- Adds sticky overflow/underflow error flags with a clear input, and defined simultaneous read/write behaviour at full and empty.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  write request
rd_en  input  1  read request
data_in  input  WIDTH  write data
clr_err  input  1  synchronous clear of overflow/underflow
data_out  output  WIDTH  registered read data
rd_valid  output  1  data_out updated this cycle (1-cycle pulse per accepted read)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while rejected
underflow  output  1  sticky: read attempted while rejected

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous deassert by the system):
  - Pointers, count, data_out, rd_valid, overflow and underflow all clear to 0.
  - After reset, empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
- Storage and pointers:
  - Storage is DEPTH x WIDTH.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
- Status flags (full, empty, almost_*):
  - Combinational decodes of the count register only.
  - Never depend on the current-cycle wr_en or rd_en.
- Read acceptance: rd_acc = rd_en & !empty.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc).
  - When full, a write is accepted only if a read is accepted in the same cycle.
- Empty with wr_en and rd_en together:
  - The read is rejected; there is no fall-through.
  - The write is accepted and count becomes 1.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read, 1-cycle latency:
  - On rd_acc, data_out <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 in the next cycle.
  - Otherwise rd_valid=0 and data_out holds its previous value.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Never exceeds DEPTH or goes below 0.
- Error flags:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & !rd_acc.
  - Both are sticky until clr_err=1 or reset.
  - If clr_err coincides with a new error event, set wins.
  - A rejected access changes no pointer, count or memory.
- Reset mid-operation: contents are lost; the FIFO reads as empty, and a pending rd_valid pulse is suppressed.

Test Plan:
- Reset, then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, data_out=0, overflow=0, underflow=0.
- Write 0x1..0x10 on 16 consecutive cycles, then read 16 -> full=1 and count=16 after the writes; almost_full asserts at count=14; reads return 0x1..0x10 in order, each with rd_valid one cycle after rd_en; empty=1 at the end.
- Full FIFO: wr_en alone with 0xDEAD -> rejected, overflow=1, count=16. Then wr_en+rd_en with 0xBEEF -> both accepted, count stays 16, and 0xBEEF is read out last.
- Empty FIFO: rd_en+wr_en with 0xA5 -> underflow=1, rd_valid=0, count=1. The next read returns 0xA5.
- Wrap-around: 24 writes interleaved with reads keeping count between 1 and 4 -> data order preserved across the pointer wrap at 15->0.
- Error clear and reset: clr_err=1 -> overflow and underflow return to 0. Drop rst_n mid-burst at count=7 -> count=0 and empty=1 immediately (asynchronously), with no rd_valid after release.
